// File: rtl/sha256_tx_pkg.sv
// Shared types and constants for the SHA-256 digest byte transmitter.
// Also holds the nibble-to-lowercase-hex helper used by the encoder.
package sha256_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    TERM
  } tx_state_e;

  localparam int         RAW_LEN = 32;
  localparam int         HEX_LEN = 64;
  localparam logic [7:0] NL_BYTE = 8'h0A;

  // 0-9 map to '0'-'9'; 10-15 map to 'a'-'f' (8'h57 + 10 = 8'h61).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h57 + {4'h0, nib};
    end
    return ch;
  endfunction

endpackage

// File: rtl/sha256_hex_enc.sv
// Combinational 4-bit to lowercase ASCII hex character encoder.
module sha256_hex_enc
  import sha256_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = nibble_to_ascii(nibble);
  end

endmodule

// File: rtl/sha256_digest_tx.sv
// Captures a finished SHA-256 digest and streams it out over valid/ready,
// as 32 raw bytes or 64 lowercase hex characters, optionally newline-terminated.
module sha256_digest_tx
  import sha256_tx_pkg::*;
#(
  parameter bit HEX_ASCII = 1'b0,
  parameter bit APPEND_NL = 1'b0,
  parameter int IDX_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digest_valid,
  input  logic [255:0]     digest_i,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  output logic             busy,
  output logic [IDX_W-1:0] byte_idx,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int               DATA_LEN      = HEX_ASCII ? HEX_LEN : RAW_LEN;
  localparam int               SHIFT_STEP    = HEX_ASCII ? 4 : 8;
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_LEN - 1);

  tx_state_e        state_q,    state_d;
  logic [255:0]     shift_q,    shift_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic             armed_q,    armed_d;
  logic             overrun_q,  overrun_d;
  logic             dv_prev_q,  dv_prev_d;

  logic [7:0] hex_char;
  logic       last_data;
  logic       dv_rise;

  sha256_hex_enc u_hex_enc (
    .nibble (shift_q[255:252]),
    .ascii  (hex_char)
  );

  assign last_data = (byte_idx_q == LAST_DATA_IDX);
  assign dv_rise   = digest_valid && !dv_prev_q;
  assign busy      = (state_q != IDLE);
  assign byte_idx  = byte_idx_q;
  assign overrun   = overrun_q;

  // The head of the shift register is always the next symbol to send, so the
  // presented byte depends only on registered state and holds during stalls.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    armed_d    = armed_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!digest_valid) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          shift_d    = digest_i;
          armed_d    = 1'b0;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        tx_valid = 1'b1;
        tx_data  = HEX_ASCII ? hex_char : shift_q[255:248];
        tx_last  = last_data && !APPEND_NL;
        if (tx_ready) begin
          shift_d = shift_q << SHIFT_STEP;
          if (!last_data) begin
            byte_idx_d = byte_idx_q + 1'b1;
          end else if (APPEND_NL) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = TERM;
          end else begin
            byte_idx_d = '0;
            state_d    = IDLE;
          end
        end
      end

      TERM: begin
        tx_valid = 1'b1;
        tx_data  = NL_BYTE;
        tx_last  = 1'b1;
        if (tx_ready) begin
          byte_idx_d = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A fresh digest offered mid-frame is dropped and flagged; a set beats a
  // simultaneous clear so no drop event is ever lost.
  always_comb begin
    dv_prev_d = digest_valid;
    overrun_d = overrun_q;
    if (dv_rise && busy) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      armed_q    <= 1'b1;
      overrun_q  <= 1'b0;
      dv_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      armed_q    <= armed_d;
      overrun_q  <= overrun_d;
      dv_prev_q  <= dv_prev_d;
    end
  end

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Scoreboard bench for sha256_digest_tx: a raw-mode and a hex+newline instance,
// expected bytes queued at stimulus time and checked by per-instance monitors.
module tb_sha256_digest_tx;

  localparam logic [255:0] DIGEST_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIGEST_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [255:0] digest;
  logic         rst_r, dv_r, ready_r, clr_r;
  logic         rst_h, dv_h, ready_h, clr_h;
  logic         valid_r, last_r, busy_r, ovr_r;
  logic         valid_h, last_h, busy_h, ovr_h;
  logic [7:0]   data_r, data_h;
  logic [6:0]   idx_r, idx_h;

  sha256_digest_tx #(.HEX_ASCII(1'b0), .APPEND_NL(1'b0), .IDX_W(7)) dut_raw (
    .clk          (clk),
    .rst          (rst_r),
    .digest_valid (dv_r),
    .digest_i     (digest),
    .tx_valid     (valid_r),
    .tx_ready     (ready_r),
    .tx_data      (data_r),
    .tx_last      (last_r),
    .busy         (busy_r),
    .byte_idx     (idx_r),
    .overrun      (ovr_r),
    .clr_overrun  (clr_r)
  );

  sha256_digest_tx #(.HEX_ASCII(1'b1), .APPEND_NL(1'b1), .IDX_W(7)) dut_hex (
    .clk          (clk),
    .rst          (rst_h),
    .digest_valid (dv_h),
    .digest_i     (digest),
    .tx_valid     (valid_h),
    .tx_ready     (ready_h),
    .tx_data      (data_h),
    .tx_last      (last_h),
    .busy         (busy_h),
    .byte_idx     (idx_h),
    .overrun      (ovr_h),
    .clr_overrun  (clr_h)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [6:0] idx;
  } exp_t;

  exp_t exp_r[$];
  exp_t exp_h[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  string hex_chars = "0123456789abcdef";

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushRaw(input logic [255:0] d);
    for (int k = 0; k < 32; k++) begin
      exp_r.push_back('{data: d[255-8*k -: 8], last: (k == 31), idx: 7'(k)});
    end
  endtask

  task automatic pushHex(input logic [255:0] d);
    logic [3:0] nib;
    for (int k = 0; k < 64; k++) begin
      nib = d[255-4*k -: 4];
      exp_h.push_back('{data: hex_chars[int'(nib)], last: 1'b0, idx: 7'(k)});
    end
    exp_h.push_back('{data: 8'h0A, last: 1'b1, idx: 7'd64});
  endtask

  // Offer one digest as a single-cycle pulse and check the one-cycle latency.
  task automatic applyStimulus(input bit hex, input logic [255:0] d);
    digest = d;
    if (hex) begin
      checkOutput("hex_pre_capture_valid", 32'(valid_h), 32'd0);
      dv_h = 1'b1;
      pushHex(d);
    end else begin
      checkOutput("raw_pre_capture_valid", 32'(valid_r), 32'd0);
      dv_r = 1'b1;
      pushRaw(d);
    end
    tick();
    dv_h = 1'b0;
    dv_r = 1'b0;
    if (hex) begin
      checkOutput("hex_first_valid", 32'(valid_h), 32'd1);
      checkOutput("hex_first_idx", 32'(idx_h), 32'd0);
    end else begin
      checkOutput("raw_first_valid", 32'(valid_r), 32'd1);
      checkOutput("raw_first_idx", 32'(idx_r), 32'd0);
    end
  endtask

  task automatic waitDrain(input bit hex, input int budget, input bit rand_ready);
    int c = 0;
    int left;
    left = hex ? exp_h.size() : exp_r.size();
    while (left != 0 && c < budget) begin
      if (rand_ready) ready_r = 1'($urandom_range(0, 1));
      tick();
      c++;
      left = hex ? exp_h.size() : exp_r.size();
    end
    ready_r = 1'b1;
    checkOutput(hex ? "hex_frame_drain" : "raw_frame_drain", 32'(left), 32'd0);
    checkOutput(hex ? "hex_idle_after_frame" : "raw_idle_after_frame",
                32'(hex ? busy_h : busy_r), 32'd0);
  endtask

  // Raw monitor: scoreboard pop on handshake plus stall stability.
  logic       pv_r = 1'b0, pr_r = 1'b0, pl_r = 1'b0;
  logic [7:0] pd_r = 8'h00;
  logic [6:0] pi_r = 7'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_r) begin
      pv_r = 1'b0;
    end else begin
      if (pv_r && !pr_r) begin
        checkOutput("raw_stall_valid", 32'(valid_r), 32'd1);
        checkOutput("raw_stall_data", 32'(data_r), 32'(pd_r));
        checkOutput("raw_stall_idx", 32'(idx_r), 32'(pi_r));
        checkOutput("raw_stall_last", 32'(last_r), 32'(pl_r));
      end
      if (valid_r && ready_r) begin
        if (exp_r.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL raw_unexpected_byte at %0t: got %0h, expected no byte", $time, data_r);
        end else begin
          e = exp_r.pop_front();
          checkOutput("raw_data", 32'(data_r), 32'(e.data));
          checkOutput("raw_last", 32'(last_r), 32'(e.last));
          checkOutput("raw_idx", 32'(idx_r), 32'(e.idx));
        end
      end
      pv_r = valid_r;
      pr_r = ready_r;
      pd_r = data_r;
      pi_r = idx_r;
      pl_r = last_r;
    end
  end

  // Hex monitor: same checks for the hex+newline instance.
  logic       pv_h = 1'b0, pr_h = 1'b0, pl_h = 1'b0;
  logic [7:0] pd_h = 8'h00;
  logic [6:0] pi_h = 7'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_h) begin
      pv_h = 1'b0;
    end else begin
      if (pv_h && !pr_h) begin
        checkOutput("hex_stall_valid", 32'(valid_h), 32'd1);
        checkOutput("hex_stall_data", 32'(data_h), 32'(pd_h));
        checkOutput("hex_stall_idx", 32'(idx_h), 32'(pi_h));
        checkOutput("hex_stall_last", 32'(last_h), 32'(pl_h));
      end
      if (valid_h && ready_h) begin
        if (exp_h.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL hex_unexpected_byte at %0t: got %0h, expected no byte", $time, data_h);
        end else begin
          e = exp_h.pop_front();
          checkOutput("hex_data", 32'(data_h), 32'(e.data));
          checkOutput("hex_last", 32'(last_h), 32'(e.last));
          checkOutput("hex_idx", 32'(idx_h), 32'(e.idx));
        end
      end
      pv_h = valid_h;
      pr_h = ready_h;
      pd_h = data_h;
      pi_h = idx_h;
      pl_h = last_h;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    digest  = '0;
    rst_r   = 1'b1;  rst_h   = 1'b1;
    dv_r    = 1'b0;  dv_h    = 1'b0;
    ready_r = 1'b1;  ready_h = 1'b1;
    clr_r   = 1'b0;  clr_h   = 1'b0;
    tick();
    tick();
    rst_r = 1'b0;
    rst_h = 1'b0;

    // Reset state of both instances.
    checkOutput("rst_raw_valid", 32'(valid_r), 32'd0);
    checkOutput("rst_raw_data", 32'(data_r), 32'd0);
    checkOutput("rst_raw_last", 32'(last_r), 32'd0);
    checkOutput("rst_raw_busy", 32'(busy_r), 32'd0);
    checkOutput("rst_raw_idx", 32'(idx_r), 32'd0);
    checkOutput("rst_raw_overrun", 32'(ovr_r), 32'd0);
    checkOutput("rst_hex_valid", 32'(valid_h), 32'd0);
    checkOutput("rst_hex_data", 32'(data_h), 32'd0);
    checkOutput("rst_hex_last", 32'(last_h), 32'd0);
    checkOutput("rst_hex_busy", 32'(busy_h), 32'd0);
    checkOutput("rst_hex_idx", 32'(idx_h), 32'd0);
    checkOutput("rst_hex_overrun", 32'(ovr_h), 32'd0);
    tick();

    // Raw frame at full rate.
    applyStimulus(1'b0, DIGEST_ABC);
    waitDrain(1'b0, 200, 1'b0);

    // Hex frame with newline terminator.
    applyStimulus(1'b1, DIGEST_ABC);
    waitDrain(1'b1, 300, 1'b0);

    // Raw frame under random backpressure.
    tick();
    applyStimulus(1'b0, DIGEST_ABC);
    waitDrain(1'b0, 1000, 1'b1);

    // Level-high digest_valid with a second rising edge mid-frame.
    tick();
    digest = DIGEST_ABC;
    dv_r   = 1'b1;
    pushRaw(DIGEST_ABC);
    tick();
    repeat (5) tick();
    dv_r = 1'b0;
    tick();
    dv_r = 1'b1;
    tick();
    checkOutput("overrun_set", 32'(ovr_r), 32'd1);
    checkOutput("overrun_frame_busy", 32'(busy_r), 32'd1);
    waitDrain(1'b0, 200, 1'b0);
    repeat (10) tick();
    checkOutput("no_retrigger_busy", 32'(busy_r), 32'd0);
    checkOutput("no_retrigger_valid", 32'(valid_r), 32'd0);
    checkOutput("overrun_sticky", 32'(ovr_r), 32'd1);
    clr_r = 1'b1;
    tick();
    clr_r = 1'b0;
    checkOutput("overrun_cleared", 32'(ovr_r), 32'd0);
    dv_r = 1'b0;
    tick();
    applyStimulus(1'b0, DIGEST_EMPTY);
    repeat (3) tick();
    dv_r  = 1'b1;
    clr_r = 1'b1;
    tick();
    dv_r  = 1'b0;
    clr_r = 1'b0;
    checkOutput("overrun_set_wins", 32'(ovr_r), 32'd1);
    waitDrain(1'b0, 200, 1'b0);
    clr_r = 1'b1;
    tick();
    clr_r = 1'b0;
    checkOutput("overrun_cleared_again", 32'(ovr_r), 32'd0);

    // Reset while byte 10 is presented aborts the frame.
    tick();
    applyStimulus(1'b0, DIGEST_ABC);
    c = 0;
    while (idx_r != 7'd10 && c < 100) begin
      tick();
      c++;
    end
    checkOutput("reach_byte_10", 32'(idx_r), 32'd10);
    rst_r = 1'b1;
    tick();
    rst_r = 1'b0;
    exp_r.delete();
    checkOutput("midrst_valid", 32'(valid_r), 32'd0);
    checkOutput("midrst_busy", 32'(busy_r), 32'd0);
    checkOutput("midrst_idx", 32'(idx_r), 32'd0);
    repeat (3) tick();
    checkOutput("midrst_stays_idle", 32'(valid_r), 32'd0);
    applyStimulus(1'b0, DIGEST_EMPTY);
    waitDrain(1'b0, 200, 1'b0);

    // Two digests separated by one low cycle: two idle cycles between frames.
    tick();
    applyStimulus(1'b0, DIGEST_ABC);
    c = 0;
    while (!(valid_r && ready_r && last_r) && c < 100) begin
      tick();
      c++;
    end
    checkOutput("find_last_handshake", 32'(last_r), 32'd1);
    tick();
    checkOutput("gap_cycle1_valid", 32'(valid_r), 32'd0);
    tick();
    applyStimulus(1'b0, DIGEST_EMPTY);
    waitDrain(1'b0, 200, 1'b0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
